apb_fifo_bridge: RTL and testbench
==================================

Name: apb_fifo_bridge

Overview:
Parametrised single-clock APB slave that bridges the register bus to a TX stream and an RX stream through two internal synchronous FIFOs. It replaces the fixed 8-bit dual-clock apb_to_fifo wrapper feeding the I2C core. It adds configurable width and depth, level and status registers, flush, overflow/underflow error signalling and a threshold interrupt.

Parameters:
DATA_WIDTH, 8, width of PWDATA/PRDATA and of both FIFO entries
ADDR_WIDTH, 7, width of PADDR
TX_DEPTH, 8, TX FIFO entries; power of 2, >=2, < 2**DATA_WIDTH
RX_DEPTH, 8, RX FIFO entries; same constraints

Ports:
PCLK  in  1  single clock for the whole block
PRESET  in  1  synchronous active-high reset
PSELx  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_WIDTH  register address
PWDATA  in  DATA_WIDTH  write data
PRDATA  out  DATA_WIDTH  read data, valid in access phase
PREADY  out  1  transfer complete
PSLVERR  out  1  transfer error, valid with PREADY
tx_data  out  DATA_WIDTH  TX FIFO head
tx_valid  out  1  TX FIFO non-empty and CTRL.EN
tx_ready  in  1  consumer accepts tx_data
rx_data  in  DATA_WIDTH  incoming byte/word
rx_valid  in  1  rx_data valid
rx_ready  out  1  RX FIFO not full and CTRL.EN
irq  out  1  registered interrupt

Behaviour:
- Reset (PRESET=1 at a PCLK edge): both FIFOs emptied, pointers and levels 0, CTRL=0, RX_THRESH=1, TX_THRESH=0, sticky flags 0, irq=0. Reset mid-transfer abandons the transfer; data is not preserved.
- APB: zero wait. PREADY=1 whenever PSELx&PENABLE, otherwise 0. PRDATA/PSLVERR are combinational in the access phase and 0 outside it. Side effects fire on the PCLK edge at which PSELx&PENABLE&PREADY.
- Register map (PADDR value):
  - 0x00 TXDATA W: push. Reads return 0.
  - 0x01 RXDATA R: pop head. Writes are ignored.
  - 0x02 STATUS: [0]tx_empty [1]tx_full [2]rx_empty [3]rx_full [4]tx_ovf [5]rx_unf. Bits 4/5 are sticky and cleared by writing 1. Other bits are RO.
  - 0x03 CTRL RW: [0]EN [1]TX_FLUSH [2]RX_FLUSH [3]IRQ_RX_EN [4]IRQ_TX_EN. Flush bits self-clear and read 0.
  - 0x04 TXLVL R; 0x05 RXLVL R (zero-extended counts).
  - 0x06 RX_THRESH RW; 0x07 TX_THRESH RW.
  - Any other address: PSLVERR=1, PRDATA=0, no effect.
- TXDATA write when tx_full: PSLVERR=1, data dropped, tx_ovf set. This applies even if the stream pops the same cycle; full is evaluated from the registered count.
- RXDATA read when rx_empty: PSLVERR=1, PRDATA=0, rx_unf set.
- Stream side:
  - TX pop on tx_valid&tx_ready.
  - RX push on rx_valid&rx_ready.
  - tx_data holds the FIFO head even when EN=0; only tx_valid is gated.
- Simultaneous push and pop on one FIFO (non-full, non-empty): both occur and the level is unchanged. Empty FIFO with push+pop: pop invalid, push only.
- Flush has priority over push and pop in the same cycle. The FIFO is empty next cycle, and any same-cycle push is discarded without setting ovf.
- Level counters: $clog2(DEPTH+1) bits. Pointers: $clog2(DEPTH) bits and wrap modulo DEPTH.
- irq is registered: irq <= (IRQ_RX_EN & RX_THRESH!=0 & rx_level>=RX_THRESH) | (IRQ_TX_EN & tx_level<=TX_THRESH). It is level-type with one cycle of latency from the level change.
- Single clock only; no CDC inside.

Decomposition:
- Package apb_fifo_pkg: register address constants, STATUS/CTRL bit index constants, reset values of the threshold registers.
- Sub-module sync_fifo (params WIDTH, DEPTH), instantiated twice.
  - Ports: clk, rst, push, pop, flush, wdata, rdata(head), full, empty, level.
- Top holds the APB decode, registers, error logic and irq.

Test Plan:
1. Reset, then read STATUS -> 0x05 (tx_empty, rx_empty). Read CTRL -> 0x00, RX_THRESH -> 0x01. tx_valid=0, rx_ready=0, irq=0.
2. CTRL=0x01; write TXDATA 0x55 then 0xF5, tx_ready=0 -> TXLVL=2, tx_data=0x55. Raise tx_ready for 2 cycles -> tx_data 0x55 then 0xF5, then tx_valid=0 and TXLVL=0.
3. EN=1, drive rx_valid with 0xAA, 0xFA -> RXLVL=2. RXDATA reads return 0xAA then 0xFA with PSLVERR=0. A third read returns PRDATA=0, PSLVERR=1, and STATUS[5]=1. Writing STATUS=0x20 clears it.
4. Push 9 words into TX (depth 8) with tx_ready=0 -> the 9th gives PSLVERR=1 and STATUS bit1=1 and bit4=1. Drain all 8 and confirm order, including pointer wrap on a second fill of 8.
5. RX_THRESH=3, CTRL=0x09; push 2 RX words -> irq=0. Push a 3rd -> irq=1 one cycle after RXLVL=3. Read one word -> irq=0 next cycle.
6. TX holds 4 words; in one cycle write CTRL=0x03 while tx_ready=1 -> next cycle TXLVL=0 and tx_valid=0. Also check an access to 0x10 -> PSLVERR=1.

Source files
------------

// File: rtl/apb_fifo_pkg.sv
// apb_fifo_pkg: register map, bit positions and reset values for apb_fifo_bridge
package apb_fifo_pkg;
  localparam logic [2:0] A_TXDATA = 3'd0;
  localparam logic [2:0] A_RXDATA = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd2;
  localparam logic [2:0] A_CTRL = 3'd3;
  localparam logic [2:0] A_TXLVL = 3'd4;
  localparam logic [2:0] A_RXLVL = 3'd5;
  localparam logic [2:0] A_RX_THRESH = 3'd6;
  localparam logic [2:0] A_TX_THRESH = 3'd7;
  localparam int ST_TX_OVF = 4;
  localparam int ST_RX_UNF = 5;
  localparam int C_EN = 0;
  localparam int C_TX_FLUSH = 1;
  localparam int C_RX_FLUSH = 2;
  localparam int C_IRQ_RX_EN = 3;
  localparam int C_IRQ_TX_EN = 4;
  localparam logic [4:0] CTRL_RW_MASK = 5'b11001;
  localparam int RX_THRESH_RST = 1;
  localparam int TX_THRESH_RST = 0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush priority and registered level
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic flush,
  input logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full & ~flush;
  assign do_pop = pop & ~empty & ~flush;
  assign rdata = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/apb_fifo_bridge.sv
// apb_fifo_bridge: APB slave bridging registers to TX/RX streams through two sync FIFOs
module apb_fifo_bridge
  import apb_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input logic PCLK,
  input logic PRESET,
  input logic PSELx,
  input logic PENABLE,
  input logic PWRITE,
  input logic [ADDR_WIDTH-1:0] PADDR,
  input logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic PREADY,
  output logic PSLVERR,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic tx_valid,
  input logic tx_ready,
  input logic [DATA_WIDTH-1:0] rx_data,
  input logic rx_valid,
  output logic rx_ready,
  output logic irq
);
  localparam int TLW = $clog2(TX_DEPTH+1);
  localparam int RLW = $clog2(RX_DEPTH+1);
  logic access, hit, wr, rd, tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_unf, tx_ovf_ev, rx_unf_ev;
  logic ctrl_wr, status_wr;
  logic [TLW-1:0] tx_level;
  logic [RLW-1:0] rx_level;
  logic [DATA_WIDTH-1:0] rx_head, rx_thresh, tx_thresh;
  logic [4:0] ctrl;
  logic [5:0] status;
  logic [2:0] a;
  assign access = PSELx & PENABLE;
  assign PREADY = access;
  assign a = PADDR[2:0];
  assign hit = (PADDR >> 3) == '0;
  assign wr = access & PWRITE & hit;
  assign rd = access & ~PWRITE & hit;
  assign ctrl_wr = wr & (a == A_CTRL);
  assign status_wr = wr & (a == A_STATUS);
  assign tx_push = wr & (a == A_TXDATA);
  assign rx_pop = rd & (a == A_RXDATA);
  assign tx_ovf_ev = tx_push & tx_full;
  assign rx_unf_ev = rx_pop & rx_empty;
  assign tx_flush = ctrl_wr & PWDATA[C_TX_FLUSH];
  assign rx_flush = ctrl_wr & PWDATA[C_RX_FLUSH];
  assign tx_valid = ctrl[C_EN] & ~tx_empty;
  assign rx_ready = ctrl[C_EN] & ~rx_full;
  assign tx_pop = tx_valid & tx_ready;
  assign rx_push = rx_valid & rx_ready;
  assign PSLVERR = access & (~hit | tx_ovf_ev | rx_unf_ev);
  assign status = {rx_unf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx (
    .clk(PCLK), .rst(PRESET), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .wdata(PWDATA), .rdata(tx_data), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );
  sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx (
    .clk(PCLK), .rst(PRESET), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .wdata(rx_data), .rdata(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );
  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (a)
        A_RXDATA: PRDATA = rx_empty ? '0 : rx_head;
        A_STATUS: PRDATA = DATA_WIDTH'(status);
        A_CTRL: PRDATA = DATA_WIDTH'(ctrl);
        A_TXLVL: PRDATA = DATA_WIDTH'(tx_level);
        A_RXLVL: PRDATA = DATA_WIDTH'(rx_level);
        A_RX_THRESH: PRDATA = rx_thresh;
        A_TX_THRESH: PRDATA = tx_thresh;
        default: PRDATA = '0;
      endcase
    end
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl <= '0;
      rx_thresh <= DATA_WIDTH'(RX_THRESH_RST);
      tx_thresh <= DATA_WIDTH'(TX_THRESH_RST);
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= PWDATA[4:0] & CTRL_RW_MASK;
      if (wr && a == A_RX_THRESH) rx_thresh <= PWDATA;
      if (wr && a == A_TX_THRESH) tx_thresh <= PWDATA;
      tx_ovf <= tx_ovf_ev | (tx_ovf & ~(status_wr & PWDATA[ST_TX_OVF]));
      rx_unf <= rx_unf_ev | (rx_unf & ~(status_wr & PWDATA[ST_RX_UNF]));
      irq <= (ctrl[C_IRQ_RX_EN] & (rx_thresh != '0) & (DATA_WIDTH'(rx_level) >= rx_thresh))
           | (ctrl[C_IRQ_TX_EN] & (DATA_WIDTH'(tx_level) <= tx_thresh));
    end
  end
endmodule

// File: tb/tb_apb_fifo_bridge.sv
// tb_apb_fifo_bridge: scoreboard bench with directed APB and stream vectors
module tb_apb_fifo_bridge;
  logic PCLK = 1'b0;
  logic PRESET = 1'b1;
  logic PSELx = 1'b0;
  logic PENABLE = 1'b0;
  logic PWRITE = 1'b0;
  logic [6:0] PADDR = '0;
  logic [7:0] PWDATA = '0;
  logic [7:0] PRDATA;
  logic PREADY, PSLVERR;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_ready, irq;
  typedef struct {
    string nm;
    logic [7:0] d;
    logic e;
  } exp_t;
  exp_t aq[$];
  exp_t x;
  logic [7:0] txq[$];
  int checks = 0;
  int errors = 0;
  bit skip_tx = 1'b0;
  apb_fifo_bridge dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge PCLK) begin
    if (PSELx && PENABLE) begin
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: access at addr %0h with no expectation", PADDR);
      end else begin
        x = aq.pop_front();
        chk({x.nm, " pready"}, 32'(PREADY), 32'd1);
        chk({x.nm, " prdata"}, 32'(PRDATA), 32'(x.d));
        chk({x.nm, " pslverr"}, 32'(PSLVERR), 32'(x.e));
      end
    end
    if (tx_valid && tx_ready && !skip_tx) begin
      if (txq.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected: got %0h expected nothing", tx_data);
      end else chk("tx_data", 32'(tx_data), 32'(txq.pop_front()));
    end
  end
  task automatic apb(input logic w, input logic [6:0] ad, input logic [7:0] wd,
                     input logic [7:0] ed, input logic ee, input string nm, input bit fr);
    @(posedge PCLK); #1;
    PSELx = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = ad; PWDATA = wd;
    aq.push_back('{nm, ed, ee});
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (fr) begin
      tx_ready = 1'b1;
      skip_tx = 1'b1;
    end
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0; tx_ready = 1'b0; skip_tx = 1'b0;
  endtask
  task automatic rd_reg(input logic [6:0] ad, input logic [7:0] ed, input logic ee, input string nm);
    apb(1'b0, ad, 8'h00, ed, ee, nm, 1'b0);
  endtask
  task automatic wr_reg(input logic [6:0] ad, input logic [7:0] wd, input logic ee, input string nm);
    apb(1'b1, ad, wd, 8'h00, ee, nm, 1'b0);
  endtask
  task automatic txw(input logic [7:0] d, input logic ee);
    wr_reg(7'h00, d, ee, "txdata");
    if (!ee) txq.push_back(d);
  endtask
  task automatic rxp(input logic [7:0] d);
    chk("rx_ready", 32'(rx_ready), 32'd1);
    @(posedge PCLK); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
  endtask
  task automatic drain(input int n);
    @(posedge PCLK); #1;
    tx_ready = 1'b1;
    repeat (n) @(posedge PCLK);
    #1 tx_ready = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset rx_ready", 32'(rx_ready), 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    chk("idle prdata", 32'(PRDATA), 32'd0);
    chk("idle pready", 32'(PREADY), 32'd0);
    rd_reg(7'h02, 8'h05, 1'b0, "reset status");
    rd_reg(7'h03, 8'h00, 1'b0, "reset ctrl");
    rd_reg(7'h06, 8'h01, 1'b0, "reset rx_thresh");
    rd_reg(7'h07, 8'h00, 1'b0, "reset tx_thresh");
    rd_reg(7'h04, 8'h00, 1'b0, "reset txlvl");
    wr_reg(7'h03, 8'h01, 1'b0, "ctrl en");
    txw(8'h55, 1'b0);
    txw(8'hF5, 1'b0);
    rd_reg(7'h04, 8'h02, 1'b0, "txlvl 2");
    chk("tx head", 32'(tx_data), 32'h55);
    chk("tx_valid set", 32'(tx_valid), 32'd1);
    drain(2);
    chk("tx_valid drained", 32'(tx_valid), 32'd0);
    rd_reg(7'h04, 8'h00, 1'b0, "txlvl 0");
    rxp(8'hAA);
    rxp(8'hFA);
    rd_reg(7'h05, 8'h02, 1'b0, "rxlvl 2");
    rd_reg(7'h01, 8'hAA, 1'b0, "rxdata 1");
    rd_reg(7'h01, 8'hFA, 1'b0, "rxdata 2");
    rd_reg(7'h01, 8'h00, 1'b1, "rxdata underflow");
    rd_reg(7'h02, 8'h25, 1'b0, "status rx_unf");
    wr_reg(7'h02, 8'h20, 1'b0, "status clear unf");
    rd_reg(7'h02, 8'h05, 1'b0, "status cleared");
    for (int i = 0; i < 8; i++) txw(8'h10 + 8'(i), 1'b0);
    txw(8'h18, 1'b1);
    rd_reg(7'h02, 8'h16, 1'b0, "status full ovf");
    rd_reg(7'h04, 8'h08, 1'b0, "txlvl full");
    drain(8);
    chk("tx_valid after fill1", 32'(tx_valid), 32'd0);
    wr_reg(7'h02, 8'h10, 1'b0, "status clear ovf");
    rd_reg(7'h02, 8'h05, 1'b0, "status ovf cleared");
    for (int i = 0; i < 8; i++) txw(8'h20 + 8'(i), 1'b0);
    drain(5);
    for (int i = 0; i < 3; i++) txw(8'h28 + 8'(i), 1'b0);
    rd_reg(7'h04, 8'h06, 1'b0, "txlvl wrapped");
    drain(6);
    chk("tx_valid after fill2", 32'(tx_valid), 32'd0);
    wr_reg(7'h06, 8'h03, 1'b0, "rx_thresh 3");
    wr_reg(7'h03, 8'h09, 1'b0, "ctrl irq_rx");
    rxp(8'h01);
    rxp(8'h02);
    @(posedge PCLK); #1;
    chk("irq below thresh", 32'(irq), 32'd0);
    rxp(8'h03);
    chk("irq latency", 32'(irq), 32'd0);
    @(posedge PCLK); #1;
    chk("irq at thresh", 32'(irq), 32'd1);
    rd_reg(7'h01, 8'h01, 1'b0, "rxdata irq pop");
    chk("irq held one cycle", 32'(irq), 32'd1);
    @(posedge PCLK); #1;
    chk("irq cleared", 32'(irq), 32'd0);
    rd_reg(7'h01, 8'h02, 1'b0, "rxdata drain 2");
    rd_reg(7'h01, 8'h03, 1'b0, "rxdata drain 3");
    for (int i = 0; i < 4; i++) txw(8'h40 + 8'(i), 1'b0);
    rd_reg(7'h04, 8'h04, 1'b0, "txlvl before flush");
    apb(1'b1, 7'h03, 8'h03, 8'h00, 1'b0, "ctrl flush", 1'b1);
    txq.delete();
    chk("tx_valid after flush", 32'(tx_valid), 32'd0);
    rd_reg(7'h04, 8'h00, 1'b0, "txlvl after flush");
    rd_reg(7'h03, 8'h01, 1'b0, "ctrl flush self-clear");
    rd_reg(7'h10, 8'h00, 1'b1, "bad addr read");
    wr_reg(7'h10, 8'hFF, 1'b1, "bad addr write");
    rd_reg(7'h02, 8'h05, 1'b0, "status after bad addr");
    repeat (2) @(posedge PCLK);
    chk("apb scoreboard empty", 32'(aq.size()), 32'd0);
    chk("tx scoreboard empty", 32'(txq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
